// File: rtl/cmd_frame_pkg.sv
// cmd_frame_pkg: shared types and constants for the command frame transmitter.
//   cmd_type_e  - command kinds carried on CMD_Type
//   state_e     - serializer bit-slot states
//   HDR_*       - frame header bytes per command kind
//   NB_*        - number of bytes per frame (header included)
//   build_frame - assembles the byte list of a frame, byte 0 sent first
package cmd_frame_pkg;

    typedef enum logic [1:0] {
        CMD_WR      = 2'b00,
        CMD_RD      = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    localparam logic [7:0] HDR_WR      = 8'hAA;
    localparam logic [7:0] HDR_RD      = 8'hBB;
    localparam logic [7:0] HDR_ALU_OP  = 8'hCC;
    localparam logic [7:0] HDR_ALU_NOP = 8'hDD;

    localparam logic [2:0] NB_WR      = 3'd3;
    localparam logic [2:0] NB_RD      = 3'd2;
    localparam logic [2:0] NB_ALU_OP  = 3'd4;
    localparam logic [2:0] NB_ALU_NOP = 3'd2;

    // Byte 0 occupies the low bits and goes out first.
    typedef logic [3:0][7:0] frame_t;

    function automatic frame_t build_frame(input cmd_type_e t, input logic [7:0] addr,
                                           input logic [7:0] opa, input logic [7:0] opb,
                                           input logic [7:0] fun);
        frame_t f;
        f = '0;
        case (t)
            CMD_WR:     begin f[0] = HDR_WR;     f[1] = addr; f[2] = opa; end
            CMD_RD:     begin f[0] = HDR_RD;     f[1] = addr; end
            CMD_ALU_OP: begin f[0] = HDR_ALU_OP; f[1] = opa;  f[2] = opb; f[3] = fun; end
            default:    begin f[0] = HDR_ALU_NOP; f[1] = fun; end
        endcase
        return f;
    endfunction

    function automatic logic [2:0] frame_len(input cmd_type_e t);
        case (t)
            CMD_WR:     return NB_WR;
            CMD_RD:     return NB_RD;
            CMD_ALU_OP: return NB_ALU_OP;
            default:    return NB_ALU_NOP;
        endcase
    endfunction

endpackage

// File: rtl/cmd_frame_tx_if.sv
// cmd_frame_tx_if: command request bus (valid/ready handshake plus fields).
//   master - command source; slave - cmd_frame_tx.
interface cmd_frame_tx_if #(
    parameter int DATA_WID = 8,
    parameter int ADDR_WID = 4
);
    logic                CMD_Valid;
    logic                CMD_Ready;
    logic [1:0]          CMD_Type;
    logic [ADDR_WID-1:0] CMD_Addr;
    logic [DATA_WID-1:0] CMD_OpA;
    logic [DATA_WID-1:0] CMD_OpB;
    logic [3:0]          CMD_Fun;
    logic                PAR_EN;
    logic                PAR_TYP;

    modport master (
        output CMD_Valid, CMD_Type, CMD_Addr, CMD_OpA, CMD_OpB, CMD_Fun, PAR_EN, PAR_TYP,
        input  CMD_Ready
    );

    modport slave (
        input  CMD_Valid, CMD_Type, CMD_Addr, CMD_OpA, CMD_OpB, CMD_Fun, PAR_EN, PAR_TYP,
        output CMD_Ready
    );
endinterface

// File: rtl/uart_byte_ser.sv
// uart_byte_ser: serializes one byte per load as start(0), 8 data bits LSB
// first, optional parity, stop(1). A load during the stop slot chains the
// next byte with no idle gap.
//   clk, rst_n      - bit clock, async active-low reset
//   load            - take byte_in/par_en/par_typ (honoured in IDLE or STOP)
//   byte_in         - byte to send
//   par_en, par_typ - parity enable, 0 even / 1 odd
//   state           - current bit slot (the bit now on tx)
//   tx              - registered serial output, 1 when idle
module uart_byte_ser
    import cmd_frame_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] byte_in,
    input  logic       par_en,
    input  logic       par_typ,
    output state_e     state,
    output logic       tx
);
    state_e     state_q, state_d;
    logic [7:0] sh_q, sh_d;
    logic [2:0] cnt_q, cnt_d;
    logic       par_bit_q, par_bit_d;
    logic       par_en_q, par_en_d;
    logic       tx_q, tx_d;

    always_comb begin
        state_d   = state_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        par_bit_d = par_bit_q;
        par_en_d  = par_en_q;
        case (state_q)
            S_IDLE, S_STOP: begin
                state_d = S_IDLE;
                if (load) begin
                    state_d   = S_START;
                    sh_d      = byte_in;
                    par_bit_d = (^byte_in) ^ par_typ;
                    par_en_d  = par_en;
                end
            end
            S_START: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                cnt_d = cnt_q + 3'd1;
                sh_d  = sh_q >> 1;
                if (cnt_q == 3'd7)
                    state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: state_d = S_STOP;
            default:  state_d = S_IDLE;
        endcase

        // tx is registered, so it is chosen from the slot being entered.
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = sh_d[0];
            S_PARITY: tx_d = par_bit_q;
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sh_q      <= '0;
            cnt_q     <= '0;
            par_bit_q <= 1'b0;
            par_en_q  <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            sh_q      <= sh_d;
            cnt_q     <= cnt_d;
            par_bit_q <= par_bit_d;
            par_en_q  <= par_en_d;
            tx_q      <= tx_d;
        end
    end

    assign state = state_q;
    assign tx    = tx_q;
endmodule

// File: rtl/cmd_frame_tx.sv
// cmd_frame_tx: accepts a command on the bus, builds its byte frame and feeds
// the bytes back-to-back into uart_byte_ser.
//   CLK, RST   - bit clock, async active-low reset
//   bus        - command handshake and fields (slave side)
//   TX_OUT     - serial line
//   Busy       - frame in progress
//   Frame_Done - one-cycle pulse in the first idle cycle after a frame
module cmd_frame_tx
    import cmd_frame_pkg::*;
#(
    parameter int DATA_WID = 8,
    parameter int ADDR_WID = 4
) (
    input  logic               CLK,
    input  logic               RST,
    cmd_frame_tx_if.slave      bus,
    output logic               TX_OUT,
    output logic               Busy,
    output logic               Frame_Done
);
    frame_t              frame_q, frame_d, in_frame;
    logic [2:0]          len_q, len_d, idx_q, idx_d;
    logic                par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                ready_q, ready_d, done_q, done_d;
    logic                accept, more, ld, ld_par_en, ld_par_typ;
    logic [7:0]          ld_byte;
    logic [ADDR_WID-1:0] addr_w;
    logic [DATA_WID-1:0] opa_w, opb_w;
    state_e              ser_state;

    assign addr_w = bus.CMD_Addr;
    assign opa_w  = bus.CMD_OpA;
    assign opb_w  = bus.CMD_OpB;

    assign accept = bus.CMD_Valid & ready_q;
    assign more   = idx_q < len_q;

    always_comb begin
        in_frame   = build_frame(cmd_type_e'(bus.CMD_Type), 8'(addr_w), 8'(opa_w),
                                 8'(opb_w), 8'(bus.CMD_Fun));
        frame_d    = frame_q;
        len_d      = len_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        ready_d    = ready_q;
        done_d     = 1'b0;
        ld         = 1'b0;
        ld_byte    = frame_q[idx_q[1:0]];
        ld_par_en  = par_en_q;
        ld_par_typ = par_typ_q;
        if (accept) begin
            // Header goes straight from the bus so the start bit follows next cycle.
            frame_d    = in_frame;
            len_d      = frame_len(cmd_type_e'(bus.CMD_Type));
            idx_d      = 3'd1;
            par_en_d   = bus.PAR_EN;
            par_typ_d  = bus.PAR_TYP;
            ready_d    = 1'b0;
            ld         = 1'b1;
            ld_byte    = in_frame[0];
            ld_par_en  = bus.PAR_EN;
            ld_par_typ = bus.PAR_TYP;
        end else if (ser_state == S_STOP) begin
            if (more) begin
                ld    = 1'b1;
                idx_d = idx_q + 3'd1;
            end else begin
                done_d  = 1'b1;
                ready_d = 1'b1;
            end
        end else if (ser_state == S_IDLE) begin
            ready_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            frame_q   <= '0;
            len_q     <= '0;
            idx_q     <= '0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            frame_q   <= frame_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            par_en_q  <= par_en_d;
            par_typ_q <= par_typ_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
        end
    end

    uart_byte_ser u_ser (
        .clk     (CLK),
        .rst_n   (RST),
        .load    (ld),
        .byte_in (ld_byte),
        .par_en  (ld_par_en),
        .par_typ (ld_par_typ),
        .state   (ser_state),
        .tx      (TX_OUT)
    );

    assign bus.CMD_Ready = ready_q;
    assign Busy          = (ser_state != S_IDLE);
    assign Frame_Done    = done_q;
endmodule

// File: doc/cmd_frame_tx.md
CMD_FRAME_TX -- requirements
Module: cmd_frame_tx

Interface
REQ-001 SHALL have parameter DATA_WID, default 8, meaning command byte width (only 8 supported).
REQ-002 SHALL have parameter ADDR_WID, default 4, meaning register-file address width.
REQ-003 SHALL have port CLK, input, 1, TX bit clock (one serial bit per cycle).
REQ-004 SHALL have port RST, input, 1, reset; one clock, reset asynchronous active-low.
REQ-005 SHALL have port CMD_Valid, input, 1, command request.
REQ-006 SHALL have port CMD_Ready, output, 1, block can accept a command.
REQ-007 SHALL have port CMD_Type, input, 2, 00 RF write, 01 RF read, 10 ALU with operands, 11 ALU no operands.
REQ-008 SHALL have port CMD_Addr, input, ADDR_WID, RF address.
REQ-009 SHALL have port CMD_OpA, input, DATA_WID, write data or ALU operand A.
REQ-010 SHALL have port CMD_OpB, input, DATA_WID, ALU operand B.
REQ-011 SHALL have port CMD_Fun, input, 4, ALU function code.
REQ-012 SHALL have port PAR_EN, input, 1, parity bit enable.
REQ-013 SHALL have port PAR_TYP, input, 1, 0 even, 1 odd.
REQ-014 SHALL have port TX_OUT, output, 1, serial line to the system RX_IN.
REQ-015 SHALL have port Busy, output, 1, a frame is in progress.
REQ-016 SHALL have port Frame_Done, output, 1, one-cycle pulse at end of frame.

Function
REQ-017 SHALL accept a command on a rising CLK edge with CMD_Valid=1 and CMD_Ready=1, capturing all CMD_* fields plus PAR_EN and PAR_TYP; input changes after acceptance have no effect.
REQ-018 SHALL drive CMD_Ready=1 only in IDLE; CMD_Valid while not ready is ignored, with no queuing.
REQ-019 SHALL emit these byte sequences: WR = AA, {0,Addr}, OpA; RD = BB, {0,Addr}; ALU_OP = CC, OpA, OpB, {0,Fun}; ALU_NOP = DD, {0,Fun}. Addr and Fun are zero-extended to 8 bits.
REQ-020 SHALL serialize each byte as start bit 0, 8 data bits LSB first, optional parity bit, then stop bit 1, one bit per cycle.
REQ-021 SHALL compute parity over the 8 data bits, making total ones even when PAR_TYP=0 and odd when PAR_TYP=1.
REQ-022 SHALL send bytes back-to-back: the next start bit immediately follows the previous stop bit, with no idle cycles.
REQ-023 SHALL use FSM states IDLE, START, DATA, PARITY, STOP; PARITY is skipped when the latched PAR_EN=0.
REQ-024 SHALL transition STOP->START when bytes remain, otherwise STOP->IDLE.
REQ-025 SHALL register TX_OUT; the start bit appears in the cycle after acceptance, and TX_OUT=1 in IDLE.
REQ-026 SHALL hold Busy=1 from the cycle after acceptance through the last stop bit; Busy=0 in IDLE.
REQ-027 SHALL pulse Frame_Done for exactly one cycle, in the first IDLE cycle after the last stop bit.
REQ-028 SHALL allow a new command to be accepted in that Frame_Done cycle, giving zero-gap frames.
REQ-029 SHALL set frame length to bytes × (10 + PAR_EN) cycles, e.g. WR with parity = 33 cycles.

Reset
REQ-030 SHALL make reset assertion asynchronously force IDLE, TX_OUT=1, Busy=0, Frame_Done=0, CMD_Ready=0, and clear all counters and captured fields.
REQ-031 SHALL abort any frame in progress on mid-frame reset, with no partial bytes resumed and no Frame_Done.
REQ-032 SHALL raise CMD_Ready in the first cycle after reset deassertion.

Structure
REQ-033 SHALL place in package cmd_frame_pkg: cmd_type_e enum, state_e enum, header constants AA/BB/CC/DD, and per-type byte counts (3/2/4/2).
REQ-034 SHALL implement per-byte serialization in one sub-module, uart_byte_ser, covering byte load, bit counter, parity and stop; cmd_frame_tx sequences the bytes.

Verification
REQ-035 SHALL verify: WR Addr=2, OpA=0x21, PAR_EN=1, PAR_TYP=0 -> bytes AA,02,21 with parity bits 0,1,0, 33 cycles, then one Frame_Done pulse.
REQ-036 SHALL verify: ALU_OP OpA=0x05, OpB=0x03, Fun=0, PAR_EN=0 -> bytes CC,05,03,00, 40 cycles, no parity slots.
REQ-037 SHALL verify: RD Addr=3, PAR_TYP=1 -> bytes BB,03 with odd parity bits 1,1.
REQ-038 SHALL verify: CMD_Valid held high during Busy with changing fields -> no effect, and the next command is accepted in the Frame_Done cycle with a start bit in the following cycle.
REQ-039 SHALL verify: RST asserted mid-DATA of byte 2 -> TX_OUT=1 and Busy=0 immediately; after release, a new ALU_NOP Fun=1 -> bytes DD,01 sent correctly.
